// File: rtl/alu_rr_scheduler_pkg.sv
// alu_sched_pkg: opcodes, tag type and sizing helper shared by the
// ALU round-robin scheduler, its arbiter and the registered ALU.
package alu_sched_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_XNOR = 3'b110;

    localparam int MAX_REQ = 8;

    function automatic int tag_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int ID_W = tag_w(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: requester-side request/response bundle.
// master = requesters, slave = scheduler.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int OPCODE_SIZE = 3,
    parameter int DATA_SIZE   = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*OPCODE_SIZE-1:0] req_func;
    logic [NUM_REQ*DATA_SIZE-1:0]   req_data1;
    logic [NUM_REQ*DATA_SIZE-1:0]   req_data2;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_SIZE-1:0]           rsp_data;

    modport master (
        output req_valid, req_func, req_data1, req_data2,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_func, req_data1, req_data2,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu.sv
// alu: registered ALU, one cycle latency, shared async active-low reset.
// MUL multiplies the low halves of both operands.
module alu
    import alu_sched_pkg::*;
#(
    parameter int OPCODE_SIZE = 3,
    parameter int DATA_SIZE   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPCODE_SIZE-1:0] func,
    input  logic [DATA_SIZE-1:0]   data1,
    input  logic [DATA_SIZE-1:0]   data2,
    output logic [DATA_SIZE-1:0]   dataOut
);
    localparam int H = DATA_SIZE / 2;

    logic [DATA_SIZE-1:0] res;

    always_comb begin
        res = '0;
        unique case (func)
            ALU_ADD:  res = data1 + data2;
            ALU_SUB:  res = data1 - data2;
            ALU_MUL:  res = {{(DATA_SIZE-H){1'b0}}, data1[H-1:0]}
                          * {{(DATA_SIZE-H){1'b0}}, data2[H-1:0]};
            ALU_AND:  res = data1 & data2;
            ALU_OR:   res = data1 | data2;
            ALU_XOR:  res = data1 ^ data2;
            ALU_XNOR: res = ~(data1 ^ data2);
            default:  res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dataOut <= '0;
        else        dataOut <= res;
    end
endmodule

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting at ptr,
// with optional strict priority for requester 0.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter bit PRIO0 = 1'b0,
    localparam int PW   = tag_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (PRIO0 && req[0]) begin
            gnt[0]  = 1'b1;
            gnt_any = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!gnt_any && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = PW'(idx);
                    gnt_any  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one registered ALU among NUM_REQ requesters.
// Define ALU_SCHED_PRIO_EN to give requester 0 strict priority.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int OPCODE_SIZE = 3,
    parameter int DATA_SIZE   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_rr_scheduler_if.slave      req,
    output logic [OPCODE_SIZE-1:0] alu_func,
    output logic [DATA_SIZE-1:0]   alu_data1,
    output logic [DATA_SIZE-1:0]   alu_data2,
    input  logic [DATA_SIZE-1:0]   alu_result,
    output logic                   busy
);
    localparam int PW = tag_w(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
`ifdef ALU_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
    localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
    localparam bit PRIO = 1'b0;
    localparam logic [PW-1:0] PTR_RST = '0;
`endif

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        ptr_nxt;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_any;
    tag_t                 tag0;
    tag_t                 tag1;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_SIZE-1:0] rsp_data_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PRIO0 (PRIO)
    ) u_arb (
        .req     (req.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Grant only exists where valid is high, so a grant is a handshake.
    assign req.req_ready = gnt;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_data  = rsp_data_q;
    assign busy          = tag0.valid | tag1.valid;

    always_comb begin
        ptr_nxt = rr_ptr;
        if (gnt_any) begin
            if (PRIO && gnt_idx == '0) ptr_nxt = rr_ptr;
            else if (gnt_idx == LAST)  ptr_nxt = PTR_RST;
            else                       ptr_nxt = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_func    <= '0;
            alu_data1   <= '0;
            alu_data2   <= '0;
            rr_ptr      <= PTR_RST;
            tag0        <= '0;
            tag1        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr     <= ptr_nxt;
            tag0.valid <= gnt_any;
            tag0.id    <= ID_W'(gnt_idx);
            tag1       <= tag0;
            if (gnt_any) begin
                alu_func  <= req.req_func[gnt_idx*OPCODE_SIZE +: OPCODE_SIZE];
                alu_data1 <= req.req_data1[gnt_idx*DATA_SIZE +: DATA_SIZE];
                alu_data2 <= req.req_data2[gnt_idx*DATA_SIZE +: DATA_SIZE];
            end
            if (tag1.valid) begin
                rsp_data_q  <= alu_result;
                rsp_valid_q <= NUM_REQ'(1) << tag1.id;
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: scheduler + ALU against a queue-based model
// of arbitration order, 2-cycle latency and ALU arithmetic.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int N = 4;
    localparam int O = 3;
    localparam int D = 8;
`ifdef ALU_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
    localparam int PTR0 = 1;
`else
    localparam bit PRIO = 1'b0;
    localparam int PTR0 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NUM_REQ(N), .OPCODE_SIZE(O), .DATA_SIZE(D)) bus ();

    logic [O-1:0] alu_func;
    logic [D-1:0] alu_data1, alu_data2, alu_result;
    logic         busy;

    alu_rr_scheduler #(.NUM_REQ(N), .OPCODE_SIZE(O), .DATA_SIZE(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus.slave),
        .alu_func   (alu_func),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_result (alu_result),
        .busy       (busy)
    );

    alu #(.OPCODE_SIZE(O), .DATA_SIZE(D)) u_alu (
        .clk     (clk),
        .rst_n   (rst_n),
        .func    (alu_func),
        .data1   (alu_data1),
        .data2   (alu_data2),
        .dataOut (alu_result)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int ptr     = PTR0;

    bit           pv [N];
    logic [O-1:0] pf [N];
    logic [D-1:0] pa [N];
    logic [D-1:0] pb [N];

    int           q_due [$];
    int           q_id  [$];
    logic [D-1:0] q_dat [$];
    logic [O-1:0] q_f   [$];
    logic [D-1:0] q_a   [$];
    logic [D-1:0] q_b   [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] ref_alu(input logic [O-1:0] f,
                                             input logic [D-1:0] a,
                                             input logic [D-1:0] b);
        int x, y;
        x = int'(a);
        y = int'(b);
        case (f)
            ALU_ADD:  return D'((x + y) % 256);
            ALU_SUB:  return D'((x - y + 256) % 256);
            ALU_MUL:  return D'((x % 16) * (y % 16));
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_XNOR: return ~(a ^ b);
            default:  return '0;
        endcase
    endfunction

    function automatic int model_grant();
        int i;
        if (PRIO && pv[0]) return 0;
        for (int k = 0; k < N; k++) begin
            i = (ptr + k) % N;
            if (!(PRIO && i == 0) && pv[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit model_idle();
        bit any;
        any = q_due.size() > 0;
        for (int i = 0; i < N; i++) any |= pv[i];
        return !any;
    endfunction

    task automatic set_req(input int i, input logic [O-1:0] f,
                           input logic [D-1:0] a, input logic [D-1:0] b);
        pv[i] = 1'b1;
        pf[i] = f;
        pa[i] = a;
        pb[i] = b;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = pv[i];
            bus.req_func[i*O +: O]     = pf[i];
            bus.req_data1[i*D +: D]    = pa[i];
            bus.req_data2[i*D +: D]    = pb[i];
        end
    endtask

    task automatic clear_model();
        q_due.delete(); q_id.delete(); q_dat.delete();
        q_f.delete();   q_a.delete();  q_b.delete();
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        ptr = PTR0;
    endtask

    // mode 0: no new requests, 1: regrant ADD(i,16), 2: random
    task automatic step(input int mode);
        int g;
        logic [N-1:0] gv, ev;
        @(negedge clk);
        g  = model_grant();
        gv = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", bus.req_ready, gv);
        ev = '0;
        if (q_due.size() > 0 && q_due[0] == edge_n) begin
            ev = N'(1) << q_id[0];
            chk("rsp_valid", bus.rsp_valid, ev);
            chk("rsp_data", bus.rsp_data, q_dat[0]);
            void'(q_due.pop_front()); void'(q_id.pop_front());
            void'(q_dat.pop_front()); void'(q_f.pop_front());
            void'(q_a.pop_front());   void'(q_b.pop_front());
        end else begin
            chk("rsp_valid", bus.rsp_valid, ev);
        end
        chk("busy", busy, q_due.size() > 0);
        if (q_due.size() > 0 && q_due[q_due.size()-1] == edge_n + 2) begin
            chk("alu_func", alu_func, q_f[q_f.size()-1]);
            chk("alu_data1", alu_data1, q_a[q_a.size()-1]);
            chk("alu_data2", alu_data2, q_b[q_b.size()-1]);
        end
        @(posedge clk);
        edge_n++;
        if (g >= 0) begin
            q_due.push_back(edge_n + 2);
            q_id.push_back(g);
            q_dat.push_back(ref_alu(pf[g], pa[g], pb[g]));
            q_f.push_back(pf[g]);
            q_a.push_back(pa[g]);
            q_b.push_back(pb[g]);
            pv[g] = 1'b0;
            if (!(PRIO && g == 0))
                ptr = PRIO ? (g % (N - 1)) + 1 : (g + 1) % N;
        end
        #1;
        if (mode == 1 && g >= 0) set_req(g, ALU_ADD, D'(g), 8'h10);
        if (mode == 2) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, O'($urandom_range(0, 6)),
                            D'($urandom), D'($urandom));
        end
        drive();
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && !model_idle(); k++) step(0);
        step(0);
    endtask

    initial begin
        clear_model();
        for (int i = 0; i < N; i++) begin
            pf[i] = '0; pa[i] = '0; pb[i] = '0;
        end
        drive();
        #12;
        chk("rst_ready", bus.req_ready, '0);
        chk("rst_rsp_valid", bus.rsp_valid, '0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_func", alu_func, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        set_req(2, ALU_ADD, 8'h05, 8'h03);
        drive();
        drain();

        set_req(3, ALU_OR, 8'h30, 8'h0C);
        drive();
        step(0);
        set_req(1, ALU_SUB, 8'h10, 8'h01);
        set_req(0, ALU_AND, 8'hF0, 8'h3C);
        drive();
        drain();

        set_req(1, ALU_XOR, 8'hA5, 8'h0F);
        drive();
        step(0);
        @(posedge clk);
        edge_n++;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid, '0);
        chk("mid_rst_rsp_data", bus.rsp_data, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_func", alu_func, '0);
        chk("mid_rst_data1", alu_data1, '0);
        chk("mid_rst_data2", alu_data2, '0);
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        edge_n += 2;
        #1 rst_n = 1'b1;
        repeat (3) step(0);

        for (int i = 0; i < N; i++) set_req(i, ALU_ADD, D'(i), 8'h10);
        drive();
        repeat (8) step(1);
        drain();

        set_req(0, ALU_MUL, 8'hF3, 8'hF2);
        drive();
        drain();

        repeat (600) step(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Shares one registered `alu` instance among `NUM_REQ` requesters. Arbitration is round-robin with a valid/ready request handshake. Operands are issued into the ALU at up to one operation per cycle. Each result is routed back to the requester that owns it through a tag pipeline matched to the ALU's one-cycle register latency. It sits between the requesting datapath units and the ALU, and is the only driver of the ALU's `func`, `data1` and `data2` inputs.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `OPCODE_SIZE`, 3, ALU function code width
- `DATA_SIZE`, 8, operand/result width
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset; shared with the ALU
- `req_valid`  in  NUM_REQ  per-requester operation request
- `req_ready`  out  NUM_REQ  one-hot grant; a handshake occurs where valid&ready
- `req_func`  in  NUM_REQ*OPCODE_SIZE  packed opcodes; requester i uses slice i
- `req_data1`, `req_data2`  in  NUM_REQ*DATA_SIZE  packed operands
- `alu_func`  out  OPCODE_SIZE  registered, to ALU `func`
- `alu_data1`, `alu_data2`  out  DATA_SIZE  registered, to ALU operands
- `alu_result`  in  DATA_SIZE  ALU `dataOut`
- `rsp_valid`  out  NUM_REQ  one-hot, single-cycle result strobe
- `rsp_data`  out  DATA_SIZE  result; valid only while `rsp_valid` != 0
- `busy`  out  1  an operation is in flight (either tag stage valid)

## Operation
- Grant: combinational from `req_valid` and the round-robin pointer `rr_ptr`. Search starts at index `rr_ptr` and wraps modulo NUM_REQ. The first valid requester found gets `req_ready`. At most one bit of `req_ready` is set. `req_ready` is 0 when no request is valid.
- `req_ready` depends on `req_valid`. Requesters must not gate `req_valid` on `req_ready`. A requester holds valid, func and operands stable until its handshake.
- On a handshake by requester g:
  - `alu_func`, `alu_data1` and `alu_data2` load slice g.
  - Tag stage 0 loads {valid=1, id=g}.
  - `rr_ptr` loads (g+1) mod NUM_REQ.
- No handshake in a cycle: tag stage 0 valid clears and the ALU operand registers hold their values. The ALU continues computing on the stale operands, and that result is discarded.
- Tag stage 1 copies tag stage 0 every cycle, matching the ALU output register.
- Response register: when tag stage 1 is valid, `rsp_data` loads `alu_result` and `rsp_valid` loads onehot(id). Otherwise `rsp_valid` loads 0 and `rsp_data` holds.
- Responses cannot be back-pressured. Requesters must accept `rsp_valid` in the cycle it is asserted.
- Reset values: `alu_func`/`alu_data1`/`alu_data2` = 0, `rr_ptr` = 0, both tag stages invalid, `rsp_valid` = 0, `rsp_data` = 0.
- Reset mid-operation: all in-flight tags are dropped and no responses are produced for them. Requesters reissue after reset.
- Full throughput: a handshake is allowed in every cycle. The tag pipeline never stalls.
- Opcode 3'b010 uses only the low DATA_SIZE/2 bits of each operand. The scheduler passes operands through unmodified and does not check them.

## Timing
- Handshake at edge E0: operands on the ALU inputs after E0.
- Edge E1: ALU result captured in the ALU.
- Edge E2: `rsp_valid`/`rsp_data` update. Request-to-response latency is 2 cycles.
- Back-to-back handshakes at E0, E1, E2 produce responses after E2, E3, E4, in grant order.
- `busy` is combinational: tag0.valid | tag1.valid.
- Arbitration fairness: with all requesters continuously valid, each is granted exactly once per NUM_REQ cycles.

## Configuration
- `ALU_SCHED_PRIO_EN` defined: requester 0 is strict high priority. When `req_valid[0]`=1 it is granted regardless of `rr_ptr`, and `rr_ptr` is not updated. Requesters 1..NUM_REQ-1 share the remaining slots round-robin, with `rr_ptr` ranging over 1..NUM_REQ-1 (reset value 1).
- Not defined: pure round-robin over all requesters, as above.

## Structure
- Package `alu_sched_pkg`:
  - opcode constants `ALU_ADD`=3'b000, `ALU_SUB`=3'b001, `ALU_MUL`=3'b010, `ALU_AND`=3'b011, `ALU_OR`=3'b100, `ALU_XOR`=3'b101, `ALU_XNOR`=3'b110;
  - tag width function clog2(NUM_REQ);
  - tag struct typedef {valid, id}.
- Sub-module `rr_arbiter`: parameterised combinational grant from request vector and pointer, with an optional fixed-priority bit 0. It is reused elsewhere in the design.
- The bench instantiates `alu` alongside the scheduler; the ALU is not instantiated inside it.

## Test plan
- Single request: requester 2, func=000, 8'h05, 8'h03, one cycle → `req_ready`=4'b0100; two cycles later `rsp_valid`=4'b0100 and `rsp_data`=8'h08 for one cycle.
- All four valid continuously, with ADD of (i, 8'h10) for requester i → grants in order 0,1,2,3,0, one per cycle; responses 8'h10, 8'h11, 8'h12, 8'h13 in the same order with no gaps.
- Wrap-around: handshake by requester 3 (`rr_ptr`→0), then requesters 1 and 0 valid → requester 0 is granted first.
- MUL with 8'hF3 and 8'hF2 (DATA_SIZE=8) → `rsp_data`=8'h06 (low nibbles 3*2).
- Reset asserted one cycle after a handshake → `rsp_valid` stays 0, `busy`=0, and all outputs read 0 immediately.
- With `ALU_SCHED_PRIO_EN`, requester 0 valid for 3 cycles and requesters 1 and 2 always valid → three grants to 0, then 1, 2, 1.
